// File: rtl/otn_tx_arq.sv
// OTN transmit path with stop-and-wait ARQ: forwards FIFO frames, buffers them and
// retransmits on nack/timeout. Define OTN_TX_ARQ_STATS_EN to add the o_retrans_cnt port.
module otn_tx_arq #(
    parameter int FRAME_LEN   = 16,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        i_arq_en,
    output logic [7:0]  o_otn_tx_data,
    output logic        o_otn_tx_valid,
    output logic        o_otn_tx_sof,
    output logic        o_otn_tx_eof,
    input  logic        i_otn_tx_ack,
    input  logic        i_otn_tx_nack,
    output logic        o_retrans_req,
    output logic        o_frame_drop
`ifdef OTN_TX_ARQ_STATS_EN
    ,
    output logic [15:0] o_retrans_cnt
`endif
);

    localparam int               IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [15:0]      TO_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);

    // Handshake: a byte moves on s_axis only in a cycle where tvalid and tready are both 1;
    // tready depends on state alone, never on tvalid.
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, RESEND} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      timer_q, timer_d;
    logic [3:0]       retry_q, retry_d;
    logic             arq_q, arq_d;
    logic [1:0]       sync_q, sync_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             retrans_q, retrans_d;
    logic             drop_q, drop_d;
    logic             buf_we;
    logic [7:0]       buf_mem [FRAME_LEN];

    // Reset asserts asynchronously but the FSM only starts two edges after release.
    assign sync_d = {sync_q[0], 1'b1};

    assign s_axis_tready  = (state_q == SEND);
    assign o_otn_tx_data  = data_q;
    assign o_otn_tx_valid = valid_q;
    assign o_otn_tx_sof   = sof_q;
    assign o_otn_tx_eof   = eof_q;
    assign o_retrans_req  = retrans_q;
    assign o_frame_drop   = drop_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        arq_d     = arq_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        retrans_d = 1'b0;
        drop_d    = 1'b0;
        buf_we    = 1'b0;
        if (sync_q[1]) begin
            case (state_q)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        state_d = SEND;
                        arq_d   = i_arq_en;
                        idx_d   = '0;
                    end
                end
                SEND: begin
                    if (s_axis_tvalid) begin
                        data_d  = s_axis_tdata;
                        valid_d = 1'b1;
                        sof_d   = (idx_q == '0);
                        eof_d   = (idx_q == LAST_IDX);
                        buf_we  = arq_q;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            timer_d = '0;
                            state_d = arq_q ? WAIT_ACK : IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                WAIT_ACK: begin
                    // Ack wins over a simultaneous nack and over the timeout cycle.
                    if (i_otn_tx_ack) begin
                        state_d = IDLE;
                        retry_d = '0;
                    end else if (i_otn_tx_nack || (timer_q == TO_LAST)) begin
                        if (retry_q < MAX_R) begin
                            retrans_d = 1'b1;
                            retry_d   = retry_q + 4'd1;
                            idx_d     = '0;
                            state_d   = RESEND;
                        end else begin
                            drop_d  = 1'b1;
                            retry_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                RESEND: begin
                    data_d  = buf_mem[idx_q];
                    valid_d = 1'b1;
                    sof_d   = (idx_q == '0);
                    eof_d   = (idx_q == LAST_IDX);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = WAIT_ACK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
            arq_q     <= 1'b0;
            sync_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            retrans_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            arq_q     <= arq_d;
            sync_q    <= sync_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            retrans_q <= retrans_d;
            drop_q    <= drop_d;
        end
    end

    // Frame store keeps stale contents across reset; only completed frames are replayed.
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buf_mem[idx_q] <= s_axis_tdata;
        end
    end

`ifdef OTN_TX_ARQ_STATS_EN
    logic [15:0] retrans_cnt_q, retrans_cnt_d;

    always_comb begin
        retrans_cnt_d = retrans_cnt_q;
        if (retrans_d && (retrans_cnt_q != 16'hFFFF)) begin
            retrans_cnt_d = retrans_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retrans_cnt_q <= '0;
        end else begin
            retrans_cnt_q <= retrans_cnt_d;
        end
    end

    assign o_retrans_cnt = retrans_cnt_q;
`endif

endmodule

// File: tb/tb_otn_tx_arq.sv
// Directed bench for otn_tx_arq (FRAME_LEN=4, ACK_TIMEOUT=8, MAX_RETRY=2) with a
// cycle-stamped scoreboard of expected transmit bytes.
module tb_otn_tx_arq;
    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        i_arq_en = 1'b0;
    logic [7:0]  o_otn_tx_data;
    logic        o_otn_tx_valid;
    logic        o_otn_tx_sof;
    logic        o_otn_tx_eof;
    logic        i_otn_tx_ack = 1'b0;
    logic        i_otn_tx_nack = 1'b0;
    logic        o_retrans_req;
    logic        o_frame_drop;
`ifdef OTN_TX_ARQ_STATS_EN
    logic [15:0] o_retrans_cnt;
`endif

    otn_tx_arq #(.FRAME_LEN(FL), .ACK_TIMEOUT(8), .MAX_RETRY(2)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .i_arq_en       (i_arq_en),
        .o_otn_tx_data  (o_otn_tx_data),
        .o_otn_tx_valid (o_otn_tx_valid),
        .o_otn_tx_sof   (o_otn_tx_sof),
        .o_otn_tx_eof   (o_otn_tx_eof),
        .i_otn_tx_ack   (i_otn_tx_ack),
        .i_otn_tx_nack  (i_otn_tx_nack),
        .o_retrans_req  (o_retrans_req),
        .o_frame_drop   (o_frame_drop)
`ifdef OTN_TX_ARQ_STATS_EN
        ,
        .o_retrans_cnt  (o_retrans_cnt)
`endif
    );

    // ---------------- clock / cycle stamp ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [25:0] exp_q[$];          // {cycle, sof, eof, data}
    logic [7:0]  cur_frame [FL];
    int          tb_idx = 0;
    int          tx_cnt = 0;
    int          retrans_seen = 0;
    int          drop_seen = 0;
    int          last_retrans_cyc = -1;
    int          last_drop_cyc = -1;
    int          last_sof_cyc = -1;
    int          last_eof_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Accepted input bytes predict the transmit byte one cycle later.
    always @(negedge clk) begin
        if (rst_n && s_axis_tvalid && s_axis_tready) begin
            exp_q.push_back({16'(cyc + 1), (tb_idx == 0), (tb_idx == FL - 1), s_axis_tdata});
            cur_frame[tb_idx] = s_axis_tdata;
            tb_idx = (tb_idx + 1) % FL;
        end
    end

    always @(negedge clk) begin
        if (o_otn_tx_valid) begin
            tx_cnt++;
            if (o_otn_tx_sof) last_sof_cyc = cyc;
            if (o_otn_tx_eof) last_eof_cyc = cyc;
            if (exp_q.size() == 0)
                check("tx_unexpected_valid", {31'b0, o_otn_tx_valid}, 32'd0);
            else
                check("tx_byte", {6'b0, 16'(cyc), o_otn_tx_sof, o_otn_tx_eof, o_otn_tx_data},
                      {6'b0, exp_q.pop_front()});
        end
        if (o_retrans_req) begin
            retrans_seen++;
            last_retrans_cyc = cyc;
            for (int i = 0; i < FL; i++)
                exp_q.push_back({16'(cyc + 1 + i), (i == 0), (i == FL - 1), cur_frame[i]});
        end
        if (o_frame_drop) begin
            drop_seen++;
            last_drop_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b);
        int n;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("tready_wait", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pulse(input logic ack, input logic nack);
        i_otn_tx_ack  = ack;
        i_otn_tx_nack = nack;
        @(posedge clk);
        #1;
        i_otn_tx_ack  = 1'b0;
        i_otn_tx_nack = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base_tx, base_rt, base_dr, entry_cyc, nack_cyc, tr_hi, n;
`ifdef OTN_TX_ARQ_STATS_EN
        logic [15:0] cnt_before;
`endif
        #2 rst_n = 1'b0;
        wait_cycles(2);
        check("rst_tready", {31'b0, s_axis_tready}, 32'd0);
        check("rst_data", {24'b0, o_otn_tx_data}, 32'd0);
        check("rst_flags", {27'b0, o_otn_tx_valid, o_otn_tx_sof, o_otn_tx_eof, o_retrans_req, o_frame_drop}, 32'd0);
`ifdef OTN_TX_ARQ_STATS_EN
        check("rst_retrans_cnt", {16'b0, o_retrans_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(3);

        // Pass-through frame, no ARQ.
        i_arq_en = 1'b0;
        base_tx = tx_cnt; base_rt = retrans_seen;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        check("noarq_tready_drop", {31'b0, s_axis_tready}, 32'd0);
        pulse(1'b0, 1'b1);
        wait_cycles(14);
        check("noarq_tx_count", 32'(tx_cnt - base_tx), 32'd4);
        check("noarq_no_retrans", 32'(retrans_seen - base_rt), 32'd0);
        check("noarq_span", 32'(last_eof_cyc - last_sof_cyc), 32'd3);

        // ARQ frame, nack, replay, then ack.
        i_arq_en = 1'b1;
        base_tx = tx_cnt; base_rt = retrans_seen;
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
        @(posedge clk);
        @(posedge clk);
        #1;
        nack_cyc = cyc;
        pulse(1'b0, 1'b1);
        tr_hi = 0;
        repeat (6) begin
            @(negedge clk);
            tr_hi += int'(s_axis_tready);
        end
        check("resend_tready_low", 32'(tr_hi), 32'd0);
        check("nack_retrans_count", 32'(retrans_seen - base_rt), 32'd1);
        check("nack_retrans_cycle", 32'(last_retrans_cyc), 32'(nack_cyc + 1));
        @(posedge clk);
        #1;
        pulse(1'b1, 1'b0);
        wait_cycles(14);
        check("nack_tx_count", 32'(tx_cnt - base_tx), 32'd8);
        check("ack_no_more_retrans", 32'(retrans_seen - base_rt), 32'd1);

        // Silent far end: two timeouts replay, third drops.
        base_rt = retrans_seen; base_dr = drop_seen;
`ifdef OTN_TX_ARQ_STATS_EN
        cnt_before = o_retrans_cnt;
`endif
        push_byte(8'h5A); push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hC3);
        entry_cyc = cyc;
        n = 0;
        while (drop_seen == base_dr && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("timeout_drop_seen", 32'(drop_seen - base_dr), 32'd1);
        check("timeout_retrans_count", 32'(retrans_seen - base_rt), 32'd2);
        check("timeout_2nd_retrans_cycle", 32'(last_retrans_cyc - entry_cyc), 32'd20);
        check("timeout_drop_cycle", 32'(last_drop_cyc - entry_cyc), 32'd32);
`ifdef OTN_TX_ARQ_STATS_EN
        check("stats_retrans_cnt", {16'b0, o_retrans_cnt}, {16'b0, cnt_before + 16'd2});
`endif
        wait_cycles(14);
        check("drop_idle_no_retrans", 32'(retrans_seen - base_rt), 32'd2);

        // Ack during SEND ignored; ack+nack together count as ack.
        base_rt = retrans_seen; base_dr = drop_seen; base_tx = tx_cnt;
        push_byte(8'h10);
        i_otn_tx_ack = 1'b1;
        push_byte(8'h20);
        i_otn_tx_ack = 1'b0;
        push_byte(8'h30); push_byte(8'h40);
        pulse(1'b1, 1'b1);
        wait_cycles(14);
        check("acknack_tx_count", 32'(tx_cnt - base_tx), 32'd4);
        check("acknack_no_retrans", 32'(retrans_seen - base_rt), 32'd0);
        check("acknack_no_drop", 32'(drop_seen - base_dr), 32'd0);

        // tvalid gap mid-frame; arq_en flips mid-frame but frame stays non-ARQ.
        i_arq_en = 1'b0;
        base_rt = retrans_seen;
        push_byte(8'h01);
        i_arq_en = 1'b1;
        push_byte(8'h02);
        repeat (3) @(posedge clk);
        #1;
        push_byte(8'h03); push_byte(8'h04);
        wait_cycles(14);
        check("gap_span", 32'(last_eof_cyc - last_sof_cyc), 32'd6);
        check("midframe_arq_no_retrans", 32'(retrans_seen - base_rt), 32'd0);

        // Reset while byte 3 is offered.
        i_arq_en = 1'b1;
        push_byte(8'h71); push_byte(8'h72);
        s_axis_tdata = 8'h73;
        s_axis_tvalid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("midrst_tready", {31'b0, s_axis_tready}, 32'd0);
        check("midrst_valid", {31'b0, o_otn_tx_valid}, 32'd0);
        check("midrst_data", {24'b0, o_otn_tx_data}, 32'd0);
        check("midrst_flags", {29'b0, o_otn_tx_sof, o_otn_tx_eof, o_retrans_req}, 32'd0);
        exp_q.delete();
        tb_idx = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        i_arq_en = 1'b0;
        base_rt = retrans_seen; base_tx = tx_cnt;
        push_byte(8'h81); push_byte(8'h82); push_byte(8'h83); push_byte(8'h84);
        wait_cycles(14);
        check("postrst_tx_count", 32'(tx_cnt - base_tx), 32'd4);
        check("postrst_span", 32'(last_eof_cyc - last_sof_cyc), 32'd3);
        check("postrst_no_retrans", 32'(retrans_seen - base_rt), 32'd0);

        wait_cycles(4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/otn_tx_arq.md
OTN_TX_ARQ -- requirements
Module: otn_tx_arq

Interface
REQ-001 The module SHALL have parameter FRAME_LEN, default 16, bytes per OTN frame (range 2-256).
REQ-002 The module SHALL have parameter ACK_TIMEOUT, default 64, cycles to wait for ack/nack before retransmitting (range 1-65535).
REQ-003 The module SHALL have parameter MAX_RETRY, default 3, retransmissions allowed per frame before drop (range 0-15).
REQ-004 The module SHALL have these ports:
 i_clk  in  1  sole clock, all logic rising-edge
 i_rst_n  in  1  asynchronous active-low reset
 s_axis_tdata  in  8  frame byte from upstream RX FIFO master side
 s_axis_tvalid  in  1  FIFO byte valid
 s_axis_tready  out  1  byte accepted when tvalid&tready
 i_arq_en  in  1  board switch; ARQ buffering/retransmission enable
 o_otn_tx_data  out  8  byte leaving FPGA
 o_otn_tx_valid  out  1  o_otn_tx_data valid this cycle
 o_otn_tx_sof  out  1  first byte of frame (with valid)
 o_otn_tx_eof  out  1  last byte of frame (with valid)
 i_otn_tx_ack  in  1  one-cycle pulse, far end accepted frame
 i_otn_tx_nack  in  1  one-cycle pulse, far end rejected frame
 o_retrans_req  out  1  one-cycle pulse, retransmission starting
 o_frame_drop  out  1  one-cycle pulse, retries exhausted, frame abandoned

Function
REQ-005 FSM SHALL have states IDLE, SEND, WAIT_ACK, RESEND.
REQ-006 IDLE: s_axis_tready=0; on s_axis_tvalid=1 go SEND next cycle, latching i_arq_en into arq_q for the whole frame.
REQ-007 SEND: s_axis_tready=1; each accepted byte SHALL appear on o_otn_tx_data with o_otn_tx_valid=1 exactly one cycle later; tvalid=0 cycles SHALL produce valid=0 and hold byte index.
REQ-008 SEND: sof SHALL accompany byte index 0, eof byte index FRAME_LEN-1; index SHALL be log2-sized and wrap to 0 after FRAME_LEN-1.
REQ-009 SEND with arq_q=1: each accepted byte SHALL be written to internal FRAME_LEN x 8 buffer at its index.
REQ-010 After the FRAME_LEN-th accepted byte: arq_q=1 -> WAIT_ACK; arq_q=0 -> IDLE; tready SHALL drop the cycle after the last acceptance (no byte of the next frame accepted in that cycle).
REQ-011 WAIT_ACK: timer SHALL start at 0 on entry and increment each cycle; i_otn_tx_ack -> IDLE, retry count cleared.
REQ-012 WAIT_ACK: i_otn_tx_nack, or timer reaching ACK_TIMEOUT-1 with no ack, SHALL: if retry<MAX_RETRY, pulse o_retrans_req, increment retry, go RESEND; else pulse o_frame_drop, clear retry, go IDLE.
REQ-013 ack and nack in same cycle SHALL count as ack; ack on the timeout cycle SHALL count as ack.
REQ-014 ack/nack outside WAIT_ACK SHALL be ignored.
REQ-015 RESEND: s_axis_tready=0; buffer bytes 0..FRAME_LEN-1 SHALL be output on consecutive cycles, valid=1, with sof/eof as REQ-008; first byte one cycle after o_retrans_req; then WAIT_ACK with timer cleared.
REQ-016 i_arq_en changes mid-frame SHALL take effect only at the next IDLE->SEND.

Reset
REQ-017 i_rst_n=0 SHALL asynchronously force state IDLE, all counters/retry/timer 0, arq_q 0, and every output 0 (s_axis_tready, o_otn_tx_data=0x00, valid, sof, eof, o_retrans_req, o_frame_drop).
REQ-018 Reset mid-frame SHALL discard the partial frame; buffer contents need not be cleared; release SHALL be synchronised internally so the first active edge is clean.

Configuration
REQ-019 With OTN_TX_ARQ_STATS_EN defined, port o_retrans_cnt out 16 SHALL exist, reset to 0, increment on each o_retrans_req pulse, saturate at 0xFFFF.
REQ-020 Without OTN_TX_ARQ_STATS_EN, o_retrans_cnt and its logic SHALL be absent; all other behaviour identical.

Verification (FRAME_LEN=4, ACK_TIMEOUT=8, MAX_RETRY=2)
REQ-021 arq_en=0, FIFO bytes 11,22,33,44 contiguous -> tx 11..44 on 4 consecutive cycles, each 1 cycle after acceptance, sof on 11, eof on 44, back to IDLE, no retrans_req.
REQ-022 arq_en=1, frame AA,BB,CC,DD, nack 3 cycles after eof -> retrans_req pulse, AA..DD re-sent with sof/eof, tready=0 throughout; ack -> IDLE.
REQ-023 arq_en=1, no ack/nack -> retrans_req at 8 cycles after WAIT_ACK entry, twice; third timeout -> o_frame_drop pulse, IDLE; STATS_EN build o_retrans_cnt=2.
REQ-024 arq_en=1, ack and nack same cycle in WAIT_ACK -> IDLE, no retrans_req; ack during SEND ignored.
REQ-025 tvalid gap after byte 2 for 3 cycles -> tx valid low 3 cycles, byte index held, eof still on byte 4.
REQ-026 i_rst_n low during byte 3 of SEND -> all outputs 0 immediately; after release next FIFO byte treated as sof.
